// File: rtl/synth_pkg.sv
// Shared synth types and widths used by the voice allocator and the oscillator bank.
package synth_pkg;

    localparam int unsigned NOTE_W = 7;
    localparam int unsigned VEL_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        APPLY
    } alloc_state_t;

    typedef struct packed {
        logic              en;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  vel;
    } voice_cfg_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Allocation-age permutation: age 0 is the most recently touched voice,
// NUM_VOICES-1 the least recent.
module voice_age_tracker #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = $clog2(NUM_VOICES)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 touch,
    input  logic [AGE_W-1:0]                     touch_idx,
    output logic [NUM_VOICES-1:0][AGE_W-1:0]     age,
    output logic [AGE_W-1:0]                     oldest_idx
);

    logic [NUM_VOICES-1:0][AGE_W-1:0] age_nxt;
    logic [AGE_W-1:0]                 oldest_nxt;
    logic [AGE_W-1:0]                 touch_age;

    // Touched voice becomes youngest; only voices younger than it age by one.
    always_comb begin
        age_nxt    = age;
        oldest_nxt = oldest_idx;
        touch_age  = age[touch_idx];
        if (touch) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                if (AGE_W'(i) == touch_idx) begin
                    age_nxt[i] = '0;
                end else if (age[i] < touch_age) begin
                    age_nxt[i] = age[i] + AGE_W'(1);
                end
            end
        end
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (age_nxt[i] == AGE_W'(NUM_VOICES - 1)) begin
                oldest_nxt = AGE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                age[i] <= AGE_W'(i);
            end
            oldest_idx <= AGE_W'(NUM_VOICES - 1);
        end else begin
            age        <= age_nxt;
            oldest_idx <= oldest_nxt;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto oscillator voices,
// retriggering matches, filling free voices, and stealing the oldest otherwise.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NOTE_W     = synth_pkg::NOTE_W,
    parameter int unsigned VEL_W      = synth_pkg::VEL_W
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               ev_valid,
    output logic                               ev_ready,
    input  logic                               ev_note_on,
    input  logic [NOTE_W-1:0]                  ev_note,
    input  logic [VEL_W-1:0]                   ev_vel,
    output logic [NUM_VOICES-1:0]              voice_en,
    output logic [NUM_VOICES-1:0][NOTE_W-1:0]  voice_note,
    output logic [NUM_VOICES-1:0][VEL_W-1:0]   voice_vel,
    output logic                               steal
);
    import synth_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    alloc_state_t                      state, state_nxt;
    logic                              ev_on_q, ev_on_nxt;
    logic [NOTE_W-1:0]                 ev_note_q, ev_note_nxt;
    logic [VEL_W-1:0]                  ev_vel_q, ev_vel_nxt;
    logic [IDX_W-1:0]                  scan_idx, scan_idx_nxt;
    logic                              match_found, match_found_nxt;
    logic [IDX_W-1:0]                  match_idx, match_idx_nxt;
    logic                              free_found, free_found_nxt;
    logic [IDX_W-1:0]                  free_idx, free_idx_nxt;
    logic [IDX_W-1:0]                  oldest_q, oldest_nxt;
    logic                              ev_ready_nxt;
    logic [NUM_VOICES-1:0]             voice_en_nxt;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] voice_note_nxt;
    logic [NUM_VOICES-1:0][VEL_W-1:0]  voice_vel_nxt;
    logic                              steal_nxt;
    logic                              touch_c;
    logic [IDX_W-1:0]                  target_c;
    logic [NUM_VOICES-1:0][IDX_W-1:0]  age;
    logic [IDX_W-1:0]                  oldest_idx;

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (IDX_W)
    ) u_age (
        .clk        (clk),
        .reset_n    (reset_n),
        .touch      (touch_c),
        .touch_idx  (target_c),
        .age        (age),
        .oldest_idx (oldest_idx)
    );

    always_comb begin
        state_nxt       = state;
        ev_on_nxt       = ev_on_q;
        ev_note_nxt     = ev_note_q;
        ev_vel_nxt      = ev_vel_q;
        scan_idx_nxt    = scan_idx;
        match_found_nxt = match_found;
        match_idx_nxt   = match_idx;
        free_found_nxt  = free_found;
        free_idx_nxt    = free_idx;
        oldest_nxt      = oldest_q;
        voice_en_nxt    = voice_en;
        voice_note_nxt  = voice_note;
        voice_vel_nxt   = voice_vel;
        steal_nxt       = 1'b0;
        touch_c         = 1'b0;
        target_c        = '0;

        case (state)
            IDLE: begin
                if (ev_valid && ev_ready) begin
                    // Zero-velocity note-on is folded into note-off at latch time.
                    ev_on_nxt       = ev_note_on && (ev_vel != '0);
                    ev_note_nxt     = ev_note;
                    ev_vel_nxt      = ev_vel;
                    scan_idx_nxt    = '0;
                    match_found_nxt = 1'b0;
                    free_found_nxt  = 1'b0;
                    oldest_nxt      = oldest_idx;
                    state_nxt       = SCAN;
                end
            end
            SCAN: begin
                if (!match_found && voice_en[scan_idx] && (voice_note[scan_idx] == ev_note_q)) begin
                    match_found_nxt = 1'b1;
                    match_idx_nxt   = scan_idx;
                end
                if (!free_found && !voice_en[scan_idx]) begin
                    free_found_nxt = 1'b1;
                    free_idx_nxt   = scan_idx;
                end
                if (age[scan_idx] == IDX_W'(NUM_VOICES - 1)) begin
                    oldest_nxt = scan_idx;
                end
                if (scan_idx == IDX_W'(NUM_VOICES - 1)) begin
                    state_nxt = APPLY;
                end else begin
                    scan_idx_nxt = scan_idx + IDX_W'(1);
                end
            end
            APPLY: begin
                state_nxt = IDLE;
                if (ev_on_q) begin
                    target_c = match_found ? match_idx : (free_found ? free_idx : oldest_q);
                    steal_nxt                = !match_found && !free_found;
                    touch_c                  = 1'b1;
                    voice_en_nxt[target_c]   = 1'b1;
                    voice_note_nxt[target_c] = ev_note_q;
                    voice_vel_nxt[target_c]  = ev_vel_q;
                end else if (match_found) begin
                    voice_en_nxt[match_idx] = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ev_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_vel_q    <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            oldest_q    <= '0;
            ev_ready    <= 1'b1;
            voice_en    <= '0;
            voice_note  <= '0;
            voice_vel   <= '0;
            steal       <= 1'b0;
        end else begin
            state       <= state_nxt;
            ev_on_q     <= ev_on_nxt;
            ev_note_q   <= ev_note_nxt;
            ev_vel_q    <= ev_vel_nxt;
            scan_idx    <= scan_idx_nxt;
            match_found <= match_found_nxt;
            match_idx   <= match_idx_nxt;
            free_found  <= free_found_nxt;
            free_idx    <= free_idx_nxt;
            oldest_q    <= oldest_nxt;
            ev_ready    <= ev_ready_nxt;
            voice_en    <= voice_en_nxt;
            voice_note  <= voice_note_nxt;
            voice_vel   <= voice_vel_nxt;
            steal       <= steal_nxt;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a reference voice/age model pushes
// expected outputs per event; they are popped when the allocator applies it.
module tb_voice_allocator;

    localparam int unsigned N  = 4;
    localparam int unsigned NW = 7;
    localparam int unsigned VW = 7;

    logic                      clk;
    logic                      reset_n;
    logic                      ev_valid;
    logic                      ev_ready;
    logic                      ev_note_on;
    logic [NW-1:0]             ev_note;
    logic [VW-1:0]             ev_vel;
    logic [N-1:0]              voice_en;
    logic [N-1:0][NW-1:0]      voice_note;
    logic [N-1:0][VW-1:0]      voice_vel;
    logic                      steal;

    voice_allocator #(
        .NUM_VOICES (N),
        .NOTE_W     (NW),
        .VEL_W      (VW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_note_on (ev_note_on),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .voice_en   (voice_en),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .steal      (steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]         en;
        logic [N-1:0][NW-1:0] note;
        logic [N-1:0][VW-1:0] vel;
        logic                 steal;
    } exp_t;

    exp_t          sb[$];
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic          m_en[N];
    logic [NW-1:0] m_note[N];
    logic [VW-1:0] m_vel[N];
    int            m_age[N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_en[i]   = 1'b0;
            m_note[i] = '0;
            m_vel[i]  = '0;
            m_age[i]  = i;
        end
    endtask

    // Reference allocation: match, then lowest free, then oldest (steal).
    task automatic model_event(input logic on, input logic [NW-1:0] note, input logic [VW-1:0] vel);
        int   mt = -1;
        int   ft = -1;
        int   ot = -1;
        int   t;
        int   pa;
        exp_t e;
        e.steal = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (mt < 0 && m_en[i] && m_note[i] == note) mt = i;
            if (ft < 0 && !m_en[i]) ft = i;
            if (m_age[i] == int'(N) - 1) ot = i;
        end
        if (on && vel != '0) begin
            t  = (mt >= 0) ? mt : ((ft >= 0) ? ft : ot);
            e.steal = (mt < 0) && (ft < 0);
            pa = m_age[t];
            for (int i = 0; i < int'(N); i++) begin
                if (i == t) m_age[i] = 0;
                else if (m_age[i] < pa) m_age[i] = m_age[i] + 1;
            end
            m_en[t]   = 1'b1;
            m_note[t] = note;
            m_vel[t]  = vel;
        end else if (mt >= 0) begin
            m_en[mt] = 1'b0;
        end
        for (int i = 0; i < int'(N); i++) begin
            e.en[i]   = m_en[i];
            e.note[i] = m_note[i];
            e.vel[i]  = m_vel[i];
        end
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ev_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 64'(ev_ready), 64'd1);
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".en"},    64'(voice_en),   64'(e.en));
        check({tag, ".note"},  64'(voice_note), 64'(e.note));
        check({tag, ".vel"},   64'(voice_vel),  64'(e.vel));
        check({tag, ".steal"}, 64'(steal),      64'(e.steal));
    endtask

    task automatic send(input string tag, input logic on, input logic [NW-1:0] note, input logic [VW-1:0] vel);
        wait_ready();
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_note    = note;
        ev_vel     = vel;
        model_event(on, note, vel);
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1 check({tag, ".busy_ready"}, 64'(ev_ready), 64'd0);
        @(posedge clk);
        #1 compare_outputs(tag);
        check({tag, ".ready_back"}, 64'(ev_ready), 64'd1);
        @(posedge clk);
        #1 check({tag, ".steal_1cyc"}, 64'(steal), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 64'(ev_ready),   64'd1);
        check({tag, ".en"},    64'(voice_en),   64'd0);
        check({tag, ".note"},  64'(voice_note), 64'd0);
        check({tag, ".vel"},   64'(voice_vel),  64'd0);
        check({tag, ".steal"}, 64'(steal),      64'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        ev_valid   = 1'b0;
        ev_note_on = 1'b0;
        ev_note    = '0;
        ev_vel     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) reset_n = 1'b1;

        // Fill all four free voices in order
        send("fill60", 1'b1, 7'd60, 7'd100);
        send("fill62", 1'b1, 7'd62, 7'd90);
        send("fill64", 1'b1, 7'd64, 7'd80);
        send("fill65", 1'b1, 7'd65, 7'd70);
        check("fill.en",   64'(voice_en),   64'hF);
        check("fill.note", 64'(voice_note), 64'({7'd65, 7'd64, 7'd62, 7'd60}));

        // Steal oldest twice
        send("steal67", 1'b1, 7'd67, 7'd50);
        check("steal67.v0", 64'(voice_note[0]), 64'd67);
        send("steal69", 1'b1, 7'd69, 7'd60);
        check("steal69.v1", 64'(voice_note[1]), 64'd69);

        // Retrigger an active note
        send("retrig64", 1'b1, 7'd64, 7'd127);
        check("retrig64.vel2", 64'(voice_vel[2]),  64'd127);
        check("retrig64.note", 64'(voice_note),    64'({7'd65, 7'd64, 7'd69, 7'd67}));

        // Release paths
        send("off64", 1'b0, 7'd64, 7'd0);
        check("off64.en",    64'(voice_en),      64'b1011);
        check("off64.note2", 64'(voice_note[2]), 64'd64);
        send("on64", 1'b1, 7'd64, 7'd100);
        check("on64.en", 64'(voice_en), 64'hF);
        send("vel0_64", 1'b1, 7'd64, 7'd0);
        check("vel0_64.en", 64'(voice_en), 64'b1011);
        send("off72", 1'b0, 7'd72, 7'd0);
        check("off72.en", 64'(voice_en), 64'b1011);

        // Free voice beats oldest after release
        send("off69", 1'b0, 7'd69, 7'd0);
        send("on70", 1'b1, 7'd70, 7'd55);
        check("on70.note1", 64'(voice_note[1]), 64'd70);
        check("on70.en",    64'(voice_en),      64'b1011);

        // Mixed random traffic over a narrow note range to force collisions
        for (int k = 0; k < 16; k++) begin
            logic          on;
            logic [NW-1:0] nt;
            logic [VW-1:0] vl;
            on = ($urandom_range(0, 3) != 0);
            nt = NW'(60 + $urandom_range(0, 5));
            vl = ($urandom_range(0, 4) == 0) ? '0 : VW'($urandom_range(1, 127));
            send("rand", on, nt, vl);
        end

        // Reset during SCAN drops the pending event
        wait_ready();
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_note    = 7'd60;
        ev_vel     = 7'd90;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midscan");
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        send("after_rst61", 1'b1, 7'd61, 7'd40);
        check("after_rst61.note0", 64'(voice_note[0]), 64'd61);
        check("after_rst61.en",    64'(voice_en),      64'b0001);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
